// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, SR/Cause bit positions, exception
// codes and the exception handler entry point that fetch also redirects to.
package cp0_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam int SR_IE      = 0;
    localparam int SR_EXL     = 1;
    localparam int SR_IM_LO   = 10;
    localparam int SR_IM_HI   = 15;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_BD     = 31;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

endpackage

// File: rtl/cp0.sv
// Coprocessor-0 exception controller beside the MEM stage: arbitrates interrupts
// against pipeline exceptions, owns SR/Cause/EPC/PRId and serves mfc0/mtc0.
module cp0
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID = 32'h0000_0007
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_MEM,
    input  logic [31:0] pcValue_MEM,
    input  logic [4:0]  ExcCode_MEM,
    input  logic        BD_MEM,
    input  logic        eret_MEM,
    input  logic        cp0_WE,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    input  logic [5:0]  HWInt,
    output logic [31:0] cp0_rdata,
    output logic        flush,
    output logic        epc_WE,
    output logic [31:0] epcValue_MEM
);

    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  excCode;
    logic [31:0] epc;

    logic        intReq;
    logic        excReq;
    logic [31:0] pcAligned;
    logic [31:0] epcNext;
    logic [31:0] srValue;
    logic [31:0] causeValue;

    assign intReq = valid_MEM & ie & ~exl & (|(HWInt & im));
    assign excReq = valid_MEM & ~exl & (ExcCode_MEM != EXC_INT);
    assign flush  = intReq | excReq;
    assign epc_WE = valid_MEM & eret_MEM & ~flush;
    assign epcValue_MEM = epc;

    // A delay-slot victim restarts at its branch so the branch re-executes.
    assign pcAligned = {pcValue_MEM[31:2], 2'b00};
    assign epcNext   = BD_MEM ? (pcAligned - 32'd4) : pcAligned;

    always_comb begin
        srValue = '0;
        srValue[SR_IM_HI:SR_IM_LO] = im;
        srValue[SR_EXL] = exl;
        srValue[SR_IE]  = ie;
        causeValue = '0;
        causeValue[CAUSE_BD] = bd;
        causeValue[CAUSE_IP_HI:CAUSE_IP_LO] = ip;
        causeValue[CAUSE_EXC_HI:CAUSE_EXC_LO] = excCode;
    end

    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            CP0_SR:    cp0_rdata = srValue;
            CP0_CAUSE: cp0_rdata = causeValue;
            CP0_EPC:   cp0_rdata = epc;
            CP0_PRID:  cp0_rdata = PRID;
            default:   cp0_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im      <= '0;
            exl     <= 1'b0;
            ie      <= 1'b0;
            bd      <= 1'b0;
            ip      <= '0;
            excCode <= '0;
            epc     <= '0;
        end else begin
            ip <= HWInt;
            if (flush) begin
                exl     <= 1'b1;
                bd      <= BD_MEM;
                excCode <= intReq ? EXC_INT : ExcCode_MEM;
                epc     <= epcNext;
            end else begin
                if (epc_WE) exl <= 1'b0;
                // mtc0 and eret are never in MEM together, so ordering here is moot.
                if (cp0_WE) begin
                    if (cp0_addr == CP0_SR) begin
                        im  <= cp0_wdata[SR_IM_HI:SR_IM_LO];
                        exl <= cp0_wdata[SR_EXL];
                        ie  <= cp0_wdata[SR_IE];
                    end else if (cp0_addr == CP0_EPC) begin
                        epc <= {cp0_wdata[31:2], 2'b00};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0.sv
// Directed bench for cp0: drives MEM-stage vectors one cycle at a time and
// compares outputs and register read-back against hand-computed values.
module tb_cp0;

    logic        clk;
    logic        reset;
    logic        valid_MEM;
    logic [31:0] pcValue_MEM;
    logic [4:0]  ExcCode_MEM;
    logic        BD_MEM;
    logic        eret_MEM;
    logic        cp0_WE;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [5:0]  HWInt;
    logic [31:0] cp0_rdata;
    logic        flush;
    logic        epc_WE;
    logic [31:0] epcValue_MEM;

    int numChecks = 0;
    int numErrors = 0;

    cp0 #(.PRID(32'h0000_0007)) dut (
        .clk(clk),
        .reset(reset),
        .valid_MEM(valid_MEM),
        .pcValue_MEM(pcValue_MEM),
        .ExcCode_MEM(ExcCode_MEM),
        .BD_MEM(BD_MEM),
        .eret_MEM(eret_MEM),
        .cp0_WE(cp0_WE),
        .cp0_addr(cp0_addr),
        .cp0_wdata(cp0_wdata),
        .HWInt(HWInt),
        .cp0_rdata(cp0_rdata),
        .flush(flush),
        .epc_WE(epc_WE),
        .epcValue_MEM(epcValue_MEM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numChecks++;
        if (got !== exp) begin
            numErrors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic checkReg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        cp0_addr = addr;
        #1;
        check(tag, cp0_rdata, exp);
    endtask

    task automatic idle();
        valid_MEM   = 1'b0;
        pcValue_MEM = '0;
        ExcCode_MEM = '0;
        BD_MEM      = 1'b0;
        eret_MEM    = 1'b0;
        cp0_WE      = 1'b0;
        cp0_addr    = '0;
        cp0_wdata   = '0;
        HWInt       = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] exc,
                         input logic bd, input logic er, input logic [5:0] hw);
        valid_MEM   = v;
        pcValue_MEM = pc;
        ExcCode_MEM = exc;
        BD_MEM      = bd;
        eret_MEM    = er;
        HWInt       = hw;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        cp0_WE    = 1'b1;
        cp0_addr  = addr;
        cp0_wdata = data;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;

        // Reset state
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_epcwe", 32'(epc_WE), 32'd0);
        check("rst_epcval", epcValue_MEM, 32'd0);
        checkReg("rst_sr", 5'd12, 32'd0);
        checkReg("rst_cause", 5'd13, 32'd0);
        checkReg("rst_epc", 5'd14, 32'd0);
        checkReg("rst_prid", 5'd15, 32'h0000_0007);
        checkReg("rst_other", 5'd3, 32'd0);

        // Fetch address error, unaligned PC
        step();
        drive(1'b1, 32'h0000_3006, 5'd4, 1'b0, 1'b0, 6'd0);
        #1;
        check("adel_flush", 32'(flush), 32'd1);
        check("adel_epcwe", 32'(epc_WE), 32'd0);
        step();
        idle();
        checkReg("adel_epc", 5'd14, 32'h0000_3004);
        checkReg("adel_cause", 5'd13, 32'h0000_0010);
        checkReg("adel_sr", 5'd12, 32'h0000_0002);

        // Second exception while EXL=1 is masked
        drive(1'b1, 32'h0000_3008, 5'd12, 1'b0, 1'b0, 6'd0);
        #1;
        check("exl_mask_flush", 32'(flush), 32'd0);
        step();
        idle();
        checkReg("exl_mask_epc", 5'd14, 32'h0000_3004);

        // mtc0 EPC (low bits dropped), then eret in the next cycle sees it
        mtc0(5'd14, 32'h0000_3023);
        step();
        idle();
        checkReg("mtc0_epc", 5'd14, 32'h0000_3020);
        drive(1'b1, 32'h0000_300C, 5'd0, 1'b0, 1'b1, 6'd0);
        #1;
        check("eret_epcwe", 32'(epc_WE), 32'd1);
        check("eret_flush", 32'(flush), 32'd0);
        check("eret_epcval", epcValue_MEM, 32'h0000_3020);
        step();
        idle();
        checkReg("eret_sr", 5'd12, 32'd0);

        // Interrupt in a delay slot
        mtc0(5'd12, 32'h0000_0401);
        step();
        idle();
        checkReg("sr_write", 5'd12, 32'h0000_0401);
        drive(1'b1, 32'h0000_3010, 5'd0, 1'b1, 1'b0, 6'b000001);
        #1;
        check("int_flush", 32'(flush), 32'd1);
        step();
        idle();
        checkReg("int_epc", 5'd14, 32'h0000_300C);
        checkReg("int_cause", 5'd13, 32'h8000_0400);
        checkReg("int_sr", 5'd12, 32'h0000_0403);

        // mtc0 EPC collides with an overflow: exception wins, no write
        mtc0(5'd12, 32'h0000_0401);
        step();
        idle();
        mtc0(5'd14, 32'h0000_1234);
        drive(1'b1, 32'h0000_3040, 5'd12, 1'b0, 1'b0, 6'd0);
        #1;
        check("ov_flush", 32'(flush), 32'd1);
        step();
        idle();
        checkReg("ov_epc", 5'd14, 32'h0000_3040);
        checkReg("ov_cause", 5'd13, 32'h0000_0030);

        // eret with a pending interrupt (and an RI code): interrupt wins
        mtc0(5'd12, 32'h0000_0401);
        step();
        idle();
        drive(1'b1, 32'h0000_3050, 5'd10, 1'b0, 1'b1, 6'b000001);
        #1;
        check("eretint_epcwe", 32'(epc_WE), 32'd0);
        check("eretint_flush", 32'(flush), 32'd1);
        step();
        idle();
        checkReg("eretint_epc", 5'd14, 32'h0000_3050);
        checkReg("eretint_cause", 5'd13, 32'h0000_0400);

        // IE=0 masks all interrupts; IP still tracks HWInt
        mtc0(5'd12, 32'h0000_FC00);
        step();
        idle();
        drive(1'b1, 32'h0000_3060, 5'd0, 1'b0, 1'b0, 6'b111111);
        #1;
        check("ie0_flush", 32'(flush), 32'd0);
        mtc0(5'd12, 32'h0000_FC01);
        step();
        cp0_WE = 1'b0;
        checkReg("ie0_cause", 5'd13, 32'h0000_FC00);

        // Bubble never flushes or erets
        drive(1'b0, 32'h0000_3064, 5'd4, 1'b0, 1'b1, 6'b111111);
        #1;
        check("bubble_flush", 32'(flush), 32'd0);
        check("bubble_epcwe", 32'(epc_WE), 32'd0);

        // Bubble ends: the waiting interrupt fires on the next valid instruction
        step();
        drive(1'b1, 32'h0000_3068, 5'd0, 1'b0, 1'b0, 6'b111111);
        #1;
        check("valid_int_flush", 32'(flush), 32'd1);

        // Reset in the cycle of that pending flush overrides everything
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle();
        checkReg("rstmid_sr", 5'd12, 32'd0);
        checkReg("rstmid_cause", 5'd13, 32'd0);
        checkReg("rstmid_epc", 5'd14, 32'd0);

        // Delay-slot exception at PC 0: EPC wraps modulo 2^32
        drive(1'b1, 32'h0000_0002, 5'd5, 1'b1, 1'b0, 6'd0);
        #1;
        check("wrap_flush", 32'(flush), 32'd1);
        step();
        idle();
        checkReg("wrap_epc", 5'd14, 32'hFFFF_FFFC);
        checkReg("wrap_cause", 5'd13, 32'h8000_0014);
        check("wrap_epcval", epcValue_MEM, 32'hFFFF_FFFC);

        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

endmodule
